// File: rtl/inst_buffer_pkg.sv
// Shared types for the dispatch-to-RS instruction buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// DP_RS_PACKET mirrors the dispatch-to-RS packet layout used by the rest of
// the pipeline; .valid qualifies every other field.
package inst_buffer_pkg;

  localparam int IB_DEPTH = 8;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  dest_idx;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
  } DP_RS_PACKET;

endpackage

// File: rtl/inst_buffer.sv
// Purpose: circular FIFO between dispatch and the reservation stations.
// Latency: push at edge N is visible on out_packet after edge N (no bypass).
// Backpressure: full tells dispatch to stall; a push while full is dropped and
//   sets the sticky overflow_err.
//
// Ports:
//   clock, reset        posedge clock, asynchronous active-low reset
//   flush               discard all entries (branch taken); beats push/pop
//   in_packet           pushed iff in_packet.valid && !full && !flush
//   read_enable         RS pop pulse; ignored while empty
//   out_packet          oldest entry, show-ahead; all-zero when empty
//   full/empty/count    occupancy, decoded from the count register only
//   overflow_err        sticky, cleared only by reset
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter  int DEPTH = IB_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  DP_RS_PACKET      in_packet,
  input  logic             read_enable,
  output DP_RS_PACKET      out_packet,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow_err
);

  DP_RS_PACKET      mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic push, pop;

  // full/empty come from the registered count, so the push/pop decisions
  // below only depend on current state plus the request lines.
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign overflow_err = overflow_q;
  assign out_packet   = empty ? '0 : mem_q[head_q];

  assign push = in_packet.valid && !full && !flush;
  assign pop  = read_enable && !empty && !flush;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Pointers wrap by truncation; DEPTH is a power of two.
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
      if (in_packet.valid && full) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage carries no reset; empty masks stale contents on out_packet.
  always_ff @(posedge clock) begin
    if (push) mem_q[tail_q] <= in_packet;
  end

endmodule
